instr_queue: RTL and testbench

Multi-thread instruction buffer that sits between instruction fetch (PC + imem) and decode. It keeps one FWFT queue per hardware thread and pushes fetched {thread_id, pc, instr} entries into the owning thread's queue. Each cycle it issues one entry to decode, selected round-robin among non-empty threads. Each thread can be flushed independently on a branch redirect, and per-thread full/almost-full backpressure is returned to fetch.

---
 rtl/instr_queue_pkg.sv | 26 ++
 rtl/thread_fifo.sv | 73 +++++++
 rtl/instr_queue.sv | 111 +++++++++++
 tb/tb_instr_queue.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared configuration and payload types for the multi-thread instruction queue.
package instr_queue_pkg;

    localparam int unsigned NUM_THREADS  = 2;
    localparam int unsigned THREAD_WIDTH = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int unsigned XLEN         = 32;
    localparam int unsigned INSTR_WIDTH  = 32;
    localparam int unsigned DEPTH        = 8;
    localparam int unsigned AF_THRESH    = 2;
    localparam int unsigned CNT_WIDTH    = $clog2(DEPTH) + 1;

    // One fetched instruction as stored in a thread queue.
    typedef struct packed {
        logic [THREAD_WIDTH-1:0] thread_id;
        logic [XLEN-1:0]         pc;
        logic [INSTR_WIDTH-1:0]  instr;
    } iq_entry_t;

    // Per-thread occupancy status.
    typedef struct packed {
        logic [CNT_WIDTH-1:0] count;
        logic                 empty;
        logic                 almost_full;
    } iq_status_t;

endpackage

// File: rtl/thread_fifo.sv
// Single-thread first-word-fall-through FIFO with synchronous flush.
// Ports: clk/rst (async active-low), push/push_data write side, pop/head
// read side (head valid whenever !empty), flush clears the queue at the
// next edge, count/empty/full/almost_full report registered occupancy.
module thread_fifo #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = 2,
    parameter type         entry_t   = logic [31:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = ((32'(DEPTH) - 32'(count)) <= AF_THRESH);
    assign head        = mem[rd_ptr];

    // Flush wins over any same-cycle push/pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_queue.sv
// Multi-thread instruction buffer between fetch and decode.
// One FWFT queue per hardware thread; fetch entries are demuxed by thread id,
// one entry per cycle is offered to decode chosen round-robin among non-empty,
// non-flushing threads. Ports: fetch_* write side with per-thread
// fetch_ready_o/almost_full_o backpressure, flush_i per-thread redirect,
// issue_* / decode_ack_i / stall_i read side, empty_o and packed count_o status.
// Configuration (thread count, widths, depth, threshold) lives in instr_queue_pkg.
module instr_queue
    import instr_queue_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fetch_valid_i,
    input  logic [THREAD_WIDTH-1:0]         fetch_thread_i,
    input  logic [XLEN-1:0]                 fetch_pc_i,
    input  logic [INSTR_WIDTH-1:0]          fetch_instr_i,
    output logic [NUM_THREADS-1:0]          fetch_ready_o,
    output logic [NUM_THREADS-1:0]          almost_full_o,
    input  logic [NUM_THREADS-1:0]          flush_i,
    input  logic                            stall_i,
    output logic                            issue_valid_o,
    output logic [THREAD_WIDTH-1:0]         issue_thread_o,
    output logic [XLEN-1:0]                 issue_pc_o,
    output logic [INSTR_WIDTH-1:0]          issue_instr_o,
    input  logic                            decode_ack_i,
    output logic [NUM_THREADS-1:0]          empty_o,
    output logic [NUM_THREADS*CNT_WIDTH-1:0] count_o
);

    iq_entry_t                 fetch_entry;
    iq_entry_t                 head [NUM_THREADS];
    iq_entry_t                 sel_entry;
    iq_status_t                status [NUM_THREADS];
    logic [NUM_THREADS-1:0]    full;
    logic [NUM_THREADS-1:0]    push_en;
    logic [NUM_THREADS-1:0]    pop_en;
    logic [NUM_THREADS-1:0]    eligible;
    logic [THREAD_WIDTH-1:0]   rr_ptr;
    logic [THREAD_WIDTH-1:0]   sel;
    logic                      any_eligible;
    logic                      issue_pop;

    assign fetch_entry = '{thread_id: fetch_thread_i, pc: fetch_pc_i, instr: fetch_instr_i};

    // Per-thread queues plus push demux and status fan-out.
    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thread
        // Out-of-range thread ids never match, so such pushes are dropped.
        assign push_en[t] = fetch_valid_i && (32'(fetch_thread_i) == t) &&
                            !full[t] && !flush_i[t];
        assign pop_en[t]  = issue_pop && (32'(sel) == t);
        assign eligible[t] = !status[t].empty && !flush_i[t];

        thread_fifo #(
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH),
            .entry_t   (iq_entry_t)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (push_en[t]),
            .push_data   (fetch_entry),
            .pop         (pop_en[t]),
            .flush       (flush_i[t]),
            .head        (head[t]),
            .count       (status[t].count),
            .empty       (status[t].empty),
            .full        (full[t]),
            .almost_full (status[t].almost_full)
        );

        assign fetch_ready_o[t] = !full[t];
        assign almost_full_o[t] = status[t].almost_full;
        assign empty_o[t]       = status[t].empty;
        assign count_o[t*CNT_WIDTH +: CNT_WIDTH] = status[t].count;
    end

    // Round-robin pick: first eligible thread at or after rr_ptr, with wrap.
    always_comb begin
        logic [THREAD_WIDTH-1:0] cand;
        sel          = '0;
        any_eligible = 1'b0;
        cand         = '0;
        for (int unsigned k = 0; k < NUM_THREADS; k++) begin
            cand = THREAD_WIDTH'((32'(rr_ptr) + k) % NUM_THREADS);
            if (!any_eligible && eligible[cand]) begin
                any_eligible = 1'b1;
                sel          = cand;
            end
        end
    end

    assign issue_valid_o = any_eligible && !stall_i;
    assign issue_pop     = issue_valid_o && decode_ack_i;
    assign sel_entry     = head[sel];

    // Data is forced to zero when nothing is offered so it never shows
    // uninitialised storage.
    assign issue_thread_o = issue_valid_o ? sel_entry.thread_id : '0;
    assign issue_pc_o     = issue_valid_o ? sel_entry.pc        : '0;
    assign issue_instr_o  = issue_valid_o ? sel_entry.instr     : '0;

    // Round-robin pointer advances past the thread that was just consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (issue_pop) begin
            rr_ptr <= THREAD_WIDTH'((32'(sel) + 32'd1) % NUM_THREADS);
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;
    import instr_queue_pkg::*;

    logic                             clk;
    logic                             rst;
    logic                             fetch_valid_i;
    logic [THREAD_WIDTH-1:0]          fetch_thread_i;
    logic [XLEN-1:0]                  fetch_pc_i;
    logic [INSTR_WIDTH-1:0]           fetch_instr_i;
    logic [NUM_THREADS-1:0]           fetch_ready_o;
    logic [NUM_THREADS-1:0]           almost_full_o;
    logic [NUM_THREADS-1:0]           flush_i;
    logic                             stall_i;
    logic                             issue_valid_o;
    logic [THREAD_WIDTH-1:0]          issue_thread_o;
    logic [XLEN-1:0]                  issue_pc_o;
    logic [INSTR_WIDTH-1:0]           issue_instr_o;
    logic                             decode_ack_i;
    logic [NUM_THREADS-1:0]           empty_o;
    logic [NUM_THREADS*CNT_WIDTH-1:0] count_o;

    int n_cmp;
    int n_err;

    instr_queue dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_thread_i (fetch_thread_i),
        .fetch_pc_i     (fetch_pc_i),
        .fetch_instr_i  (fetch_instr_i),
        .fetch_ready_o  (fetch_ready_o),
        .almost_full_o  (almost_full_o),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .issue_valid_o  (issue_valid_o),
        .issue_thread_o (issue_thread_o),
        .issue_pc_o     (issue_pc_o),
        .issue_instr_o  (issue_instr_o),
        .decode_ack_i   (decode_ack_i),
        .empty_o        (empty_o),
        .count_o        (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change only just after falling edges.
    task automatic push(input int thr, input logic [31:0] pc);
        fetch_valid_i  = 1'b1;
        fetch_thread_i = THREAD_WIDTH'(thr);
        fetch_pc_i     = pc;
        fetch_instr_i  = instr_of(pc);
        @(negedge clk);
        fetch_valid_i  = 1'b0;
    endtask

    // Expect an entry on the issue port and consume it.
    task automatic ack_expect(input string tag, input int thr, input logic [31:0] pc);
        decode_ack_i = 1'b1;
        #1;
        chk({tag, "_valid"}, 64'(issue_valid_o), 64'd1);
        chk({tag, "_thread"}, 64'(issue_thread_o), 64'(thr));
        chk({tag, "_pc"}, 64'(issue_pc_o), 64'(pc));
        @(negedge clk);
        decode_ack_i = 1'b0;
    endtask

    function automatic logic [CNT_WIDTH-1:0] cnt(input int t);
        return count_o[t*CNT_WIDTH +: CNT_WIDTH];
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_thread_i = '0;
        fetch_pc_i = '0;
        fetch_instr_i = '0;
        flush_i = '0;
        stall_i = 1'b0;
        decode_ack_i = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_empty", 64'(empty_o), 64'h3);
        chk("rst_ready", 64'(fetch_ready_o), 64'h3);
        chk("rst_af", 64'(almost_full_o), 64'h0);
        chk("rst_valid", 64'(issue_valid_o), 64'h0);
        chk("rst_count", 64'(count_o), 64'h0);
        chk("rst_pc_known", 64'($isunknown(issue_pc_o)), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Fill thread 0; almost_full asserts at 6 entries.
        for (int i = 0; i < 8; i++) begin
            push(0, 32'(i * 4));
            chk($sformatf("fill_cnt%0d", i), 64'(cnt(0)), 64'(i + 1));
            chk($sformatf("fill_af%0d", i), 64'(almost_full_o[0]), (i + 1 >= 6) ? 64'd1 : 64'd0);
        end
        chk("full_ready", 64'(fetch_ready_o), 64'h2);
        push(0, 32'h40);
        chk("drop_cnt", 64'(cnt(0)), 64'd8);
        for (int i = 0; i < 8; i++) begin
            ack_expect($sformatf("drain%0d", i), 0, 32'(i * 4));
        end
        #1;
        chk("drain_valid", 64'(issue_valid_o), 64'd0);
        chk("drain_empty", 64'(empty_o), 64'h3);
        @(negedge clk);

        // Reset with entries present discards them.
        push(1, 32'h80);
        push(0, 32'h84);
        chk("pre_rst_cnt", 64'(count_o), 64'h11);
        rst = 1'b0;
        #1;
        chk("midrst_empty", 64'(empty_o), 64'h3);
        chk("midrst_valid", 64'(issue_valid_o), 64'd0);
        @(negedge clk);
        chk("midrst_count", 64'(count_o), 64'h0);
        chk("midrst_ready", 64'(fetch_ready_o), 64'h3);
        rst = 1'b1;
        @(negedge clk);

        // Round-robin alternation with constant ack.
        push(0, 32'h100);
        push(0, 32'h104);
        push(1, 32'h200);
        push(1, 32'h204);
        decode_ack_i = 1'b1;
        #1;
        chk("rr_instr", 64'(issue_instr_o), 64'(instr_of(32'h100)));
        ack_expect("rr0", 0, 32'h100);
        ack_expect("rr1", 1, 32'h200);
        ack_expect("rr2", 0, 32'h104);
        ack_expect("rr3", 1, 32'h204);
        #1;
        chk("rr_done", 64'(issue_valid_o), 64'd0);
        @(negedge clk);

        // Flush T0 while it is the selected thread, with a same-cycle push.
        push(0, 32'h300);
        push(0, 32'h304);
        push(0, 32'h308);
        push(1, 32'h400);
        push(1, 32'h404);
        #1;
        chk("pre_flush_sel", 64'(issue_thread_o), 64'd0);
        flush_i = 2'b01;
        fetch_valid_i = 1'b1;
        fetch_thread_i = '0;
        fetch_pc_i = 32'h3FC;
        fetch_instr_i = instr_of(32'h3FC);
        #1;
        chk("flush_thread", 64'(issue_thread_o), 64'd1);
        chk("flush_pc", 64'(issue_pc_o), 64'h400);
        @(negedge clk);
        flush_i = '0;
        fetch_valid_i = 1'b0;
        #1;
        chk("flush_cnt0", 64'(cnt(0)), 64'd0);
        chk("flush_cnt1", 64'(cnt(1)), 64'd2);
        chk("flush_empty0", 64'(empty_o[0]), 64'd1);
        @(negedge clk);
        ack_expect("post_flush0", 1, 32'h400);
        ack_expect("post_flush1", 1, 32'h404);
        #1;
        chk("post_flush_idle", 64'(issue_valid_o), 64'd0);
        @(negedge clk);

        // Stall blocks issue and leaves rr_ptr alone.
        push(0, 32'h500);
        push(0, 32'h504);
        push(1, 32'h600);
        ack_expect("pre_stall", 0, 32'h500);
        stall_i = 1'b1;
        decode_ack_i = 1'b1;
        #1;
        chk("stall_valid", 64'(issue_valid_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        stall_i = 1'b0;
        decode_ack_i = 1'b0;
        #1;
        chk("stall_cnt", 64'(count_o), 64'h11);
        chk("stall_rr_thread", 64'(issue_thread_o), 64'd1);
        chk("stall_rr_pc", 64'(issue_pc_o), 64'h600);
        @(negedge clk);
        ack_expect("post_stall0", 1, 32'h600);
        ack_expect("post_stall1", 0, 32'h504);

        // Full thread: same-cycle pop does not make room for a push.
        for (int i = 0; i < 8; i++) begin
            push(0, 32'h700 + 32'(i * 4));
        end
        fetch_valid_i = 1'b1;
        fetch_thread_i = '0;
        fetch_pc_i = 32'h7F0;
        fetch_instr_i = instr_of(32'h7F0);
        #1;
        chk("fullpop_ready", 64'(fetch_ready_o[0]), 64'd0);
        ack_expect("fullpop", 0, 32'h700);
        fetch_valid_i = 1'b0;
        #1;
        chk("fullpop_cnt", 64'(cnt(0)), 64'd7);
        @(negedge clk);
        for (int i = 1; i < 8; i++) begin
            ack_expect($sformatf("fulldrain%0d", i), 0, 32'h700 + 32'(i * 4));
        end
        #1;
        chk("fulldrain_idle", 64'(issue_valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
